// File: rtl/phy_pkg.sv
// rtl/phy_pkg.sv - shared states, mode encodings and UPDI frame field positions
package phy_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TX_FETCH,
      TX_LOAD,
      TX_BIT,
      RX_WAIT,
      RX_BIT,
      RX_STORE,
      FIN
   } state_t;

   typedef enum logic [1:0] {
      MODE_TX   = 2'b00,
      MODE_RX   = 2'b01,
      MODE_TXRX = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam int START_BIT  = 0;
   localparam int DATA_LSB   = 1;
   localparam int DATA_MSB   = 8;
   localparam int PARITY_BIT = 9;
   localparam int STOP0_BIT  = 10;
   localparam int STOP1_BIT  = 11;

   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/phy_bit_timer.sv
// rtl/phy_bit_timer.sv - baud tick generator, full-period or half-period preload
module phy_bit_timer #(
   parameter int BIT_DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   input  logic half,
   input  logic en,
   output logic tick
);

   localparam int CW = $clog2(BIT_DIV);
   localparam logic [CW-1:0] FULL_PRE = CW'(BIT_DIV - 1);
   localparam logic [CW-1:0] HALF_PRE = CW'(BIT_DIV / 2 - 1);

   logic [CW-1:0] cnt;

   // tick marks the last cycle of a period; the counter reloads itself on it
   assign tick = en && !load && (cnt == '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= FULL_PRE;
      end else if (load) begin
         cnt <= half ? HALF_PRE : FULL_PRE;
      end else if (en) begin
         cnt <= (cnt == '0) ? FULL_PRE : cnt - 1'b1;
      end
   end

endmodule

// File: rtl/phy_frame_engine.sv
// rtl/phy_frame_engine.sv - UPDI frame TX/RX engine over single-port frame memory; PHY_FRAME_ENGINE_PARITY_EN adds RX parity check
module phy_frame_engine
   import phy_pkg::*;
#(
   parameter int FRAME_W = 12,
   parameter int ADDR_W  = 7,
   parameter int BIT_DIV = 16,
   parameter int TO_CYC  = 4096
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [1:0]         mode,
   input  logic [ADDR_W-1:0]  tx_cnt,
   input  logic [ADDR_W-1:0]  rx_cnt,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic               csb0,
   output logic               web0,
   output logic [ADDR_W-1:0]  addr0,
   input  logic [FRAME_W-1:0] i_data,
   output logic [FRAME_W-1:0] o_data,
   input  logic               prdata,
   output logic               pwdata
);

   localparam int BW = $clog2(FRAME_W);
   localparam int TW = $clog2(TO_CYC);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_W - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TO_CYC - 1);

`ifdef PHY_FRAME_ENGINE_PARITY_EN
   localparam logic PARITY_EN = 1'b1;
`else
   localparam logic PARITY_EN = 1'b0;
`endif

   state_t              state;
   mode_t               mode_q;
   logic [ADDR_W-1:0]   tx_last;
   logic [ADDR_W-1:0]   rx_last;
   logic [FRAME_W-1:0]  sh;
   logic [BW-1:0]       bit_idx;
   logic [TW-1:0]       to_cnt;
   logic                sync1, sync2, sync3;
   logic                fall;
   logic                tick;
   logic                tmr_load, tmr_half, tmr_en;
   logic                parity_bad;
   logic                frame_err;
   logic [FRAME_W-1:0]  rx_frame;

   // sync3 only remembers the previous synchronised value for edge detection
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
         sync3 <= 1'b1;
      end else begin
         sync1 <= prdata;
         sync2 <= sync1;
         sync3 <= sync2;
      end
   end

   assign fall     = sync3 & ~sync2;
   assign rx_frame = {sync2, sh[FRAME_W-1:1]};

   assign tmr_load = (state == TX_LOAD) || ((state == RX_WAIT) && fall);
   assign tmr_half = (state == RX_WAIT);
   assign tmr_en   = (state == TX_BIT) || (state == RX_BIT);

   phy_bit_timer #(.BIT_DIV(BIT_DIV)) u_bit_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .half (tmr_half),
      .en   (tmr_en),
      .tick (tick)
   );

   // o_data holds the frame being written during RX_STORE
   assign parity_bad = o_data[PARITY_BIT] != even_parity(o_data[DATA_MSB:DATA_LSB]);
   assign frame_err  = o_data[START_BIT] | ~o_data[STOP0_BIT] | ~o_data[STOP1_BIT]
                     | (PARITY_EN & parity_bad);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         mode_q  <= MODE_TX;
         tx_last <= '0;
         rx_last <= '0;
         sh      <= '0;
         bit_idx <= '0;
         to_cnt  <= '0;
         pwdata  <= 1'b1;
         csb0    <= 1'b1;
         web0    <= 1'b1;
         addr0   <= '0;
         o_data  <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
      end else begin
         csb0 <= 1'b1;
         web0 <= 1'b1;
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  busy    <= 1'b1;
                  err     <= 1'b0;
                  addr0   <= '0;
                  mode_q  <= mode_t'(mode);
                  tx_last <= tx_cnt;
                  rx_last <= rx_cnt;
                  to_cnt  <= '0;
                  if (mode == MODE_RX) begin
                     state <= RX_WAIT;
                  end else begin
                     csb0  <= 1'b0;
                     state <= TX_FETCH;
                  end
               end
            end
            TX_FETCH: state <= TX_LOAD;
            TX_LOAD: begin
               sh      <= i_data;
               pwdata  <= i_data[0];
               bit_idx <= '0;
               state   <= TX_BIT;
            end
            TX_BIT: begin
               if (tick) begin
                  if (bit_idx != LAST_BIT) begin
                     sh      <= sh >> 1;
                     pwdata  <= sh[1];
                     bit_idx <= bit_idx + 1'b1;
                  end else begin
                     pwdata <= 1'b1;
                     if (addr0 != tx_last) begin
                        addr0 <= addr0 + 1'b1;
                        csb0  <= 1'b0;
                        state <= TX_FETCH;
                     end else if (mode_q == MODE_TXRX) begin
                        addr0  <= '0;
                        to_cnt <= '0;
                        state  <= RX_WAIT;
                     end else begin
                        done  <= 1'b1;
                        state <= FIN;
                     end
                  end
               end
            end
            RX_WAIT: begin
               if (fall) begin
                  bit_idx <= '0;
                  state   <= RX_BIT;
               end else if (to_cnt == TO_LAST) begin
                  err   <= 1'b1;
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            RX_BIT: begin
               if (tick) begin
                  sh <= rx_frame;
                  if (bit_idx == LAST_BIT) begin
                     o_data <= rx_frame;
                     csb0   <= 1'b0;
                     web0   <= 1'b0;
                     state  <= RX_STORE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end
            end
            RX_STORE: begin
               if (frame_err) err <= 1'b1;
               to_cnt <= '0;
               if (addr0 == rx_last) begin
                  done  <= 1'b1;
                  state <= FIN;
               end else begin
                  addr0 <= addr0 + 1'b1;
                  state <= RX_WAIT;
               end
            end
            FIN: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_phy_frame_engine.sv
// tb/tb_phy_frame_engine.sv - scoreboard bench for phy_frame_engine with memory model and serial line driver
module tb_phy_frame_engine;

   localparam int FW = 12;
   localparam int AW = 7;
   localparam int BD = 16;
   localparam int TO = 300;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          start = 1'b0;
   logic [1:0]    mode = 2'b00;
   logic [AW-1:0] tx_cnt = '0;
   logic [AW-1:0] rx_cnt = '0;
   logic          busy, done, err, csb0, web0;
   logic [AW-1:0] addr0;
   logic [FW-1:0] i_data = '0;
   logic [FW-1:0] o_data;
   logic          prdata = 1'b1;
   logic          pwdata;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int tx_end_cyc = 0;
   int done_cyc = 0;
   logic prev_done = 1'b0;

   logic [FW-1:0]    mem [0:(1<<AW)-1];
   logic [AW+FW-1:0] tx_q[$];
   logic [AW+FW-1:0] wr_q[$];
   logic             done_q[$];
   logic [FW-1:0]    rx_fr[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   phy_frame_engine #(.FRAME_W(FW), .ADDR_W(AW), .BIT_DIV(BD), .TO_CYC(TO)) dut (
      .clk(clk), .rst(rst), .start(start), .mode(mode), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt),
      .busy(busy), .done(done), .err(err), .csb0(csb0), .web0(web0), .addr0(addr0),
      .i_data(i_data), .o_data(o_data), .prdata(prdata), .pwdata(pwdata)
   );

   // single-port frame memory, read data one cycle after select
   always @(posedge clk) begin
      if (!rst && !csb0) begin
         if (!web0) mem[addr0] = o_data;
         else i_data <= mem[addr0];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic rx_bad(input logic [FW-1:0] f);
      logic bad = f[0] | ~f[10] | ~f[11];
`ifdef PHY_FRAME_ENGINE_PARITY_EN
      bad = bad | (f[9] != ^f[8:1]);
`endif
      return bad;
   endfunction

   function automatic logic [FW-1:0] rand_rx_frame();
      logic [FW-1:0] f = FW'($urandom);
      f[0] = 1'b0;
      if ($urandom_range(3) != 0) f[11:10] = 2'b11;
      return f;
   endfunction

   // TX monitor: every read strobe opens one frame, checked bit by bit on the line
   initial begin : tx_mon
      logic [AW+FW-1:0] e;
      logic [FW-1:0]    got;
      logic             unstable, abort, idle_hi, first;
      forever begin
         @(negedge clk);
         if (!rst && !csb0 && web0) begin
            if (tx_q.size() == 0) begin
               check("tx_fetch_pending", 32'(tx_q.size()), 32'd1);
            end else begin
               e = tx_q.pop_front();
               check("tx_fetch_addr", 32'(addr0), 32'(e[AW+FW-1:FW]));
               if (e[AW+FW-1:FW] != '0) check("tx_gap", 32'(cyc - tx_end_cyc), 32'd1);
               idle_hi = pwdata;
               abort = 1'b0;
               unstable = 1'b0;
               first = 1'b0;
               got = '0;
               @(negedge clk);
               if (rst) abort = 1'b1;
               idle_hi = idle_hi & pwdata;
               for (int b = 0; b < FW && !abort; b++) begin
                  for (int c = 0; c < BD && !abort; c++) begin
                     @(negedge clk);
                     if (rst) abort = 1'b1;
                     else begin
                        if (c == 0) first = pwdata;
                        else if (pwdata !== first) unstable = 1'b1;
                        if (c == BD / 2) got[b] = pwdata;
                     end
                  end
               end
               if (!abort) begin
                  tx_end_cyc = cyc;
                  check("tx_idle_fetch_load", 32'(idle_hi), 32'd1);
                  check("tx_frame", 32'(got), 32'(e[FW-1:0]));
                  check("tx_bit_stable", 32'(unstable), 32'd0);
               end
            end
         end
      end
   end

   always @(negedge clk) begin : wr_mon
      logic [AW+FW-1:0] e;
      if (!rst && !csb0 && !web0) begin
         if (wr_q.size() == 0) begin
            check("wr_pending", 32'(wr_q.size()), 32'd1);
         end else begin
            e = wr_q.pop_front();
            check("wr_addr", 32'(addr0), 32'(e[AW+FW-1:FW]));
            check("wr_data", 32'(o_data), 32'(e[FW-1:0]));
         end
      end
   end

   always @(negedge clk) begin : done_mon
      logic e;
      if (!rst && done) begin
         done_cyc = cyc;
         check("done_single", 32'(prev_done), 32'd0);
         if (done_q.size() == 0) begin
            check("done_pending", 32'(done_q.size()), 32'd1);
         end else begin
            e = done_q.pop_front();
            check("done_err", 32'(err), 32'(e));
            check("done_busy", 32'(busy), 32'd1);
         end
      end
      prev_done = done;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pulse_start(input logic [1:0] m, input logic [AW-1:0] tc, input logic [AW-1:0] rc);
      @(posedge clk); #1;
      mode = m; tx_cnt = tc; rx_cnt = rc; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_idle(input int budget);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("busy_release", 32'(busy), 32'd0);
      tick(1);
   endtask

   task automatic wait_txq(input int target, input int budget);
      int k = 0;
      while (tx_q.size() > target && k < budget) begin
         @(negedge clk);
         k++;
      end
      check("tx_progress", 32'(tx_q.size()), 32'(target));
   endtask

   task automatic send_rx_frame(input logic [FW-1:0] f);
      int j[FW+1];
      j[0] = 0;
      j[FW] = 0;
      for (int k = 1; k < FW; k++) j[k] = int'($urandom_range(6)) - 3;
      for (int k = 0; k < FW; k++) begin
         prdata = f[k];
         repeat (BD + j[k+1] - j[k]) @(posedge clk);
         #1;
      end
      prdata = 1'b1;
      repeat (BD + int'($urandom_range(BD))) @(posedge clk);
      #1;
   endtask

   task automatic run_tx(input logic [1:0] m, input int n, input logic fill);
      for (int i = 0; i < n; i++) begin
         if (fill) mem[i] = FW'($urandom);
         tx_q.push_back({AW'(i), mem[i]});
      end
      done_q.push_back(1'b0);
      pulse_start(m, AW'(n - 1), AW'(0));
      wait_idle(n * FW * BD * 2 + 100);
      check("tx_err", 32'(err), 32'd0);
   endtask

   task automatic run_rx();
      logic bad = 1'b0;
      foreach (rx_fr[i]) begin
         wr_q.push_back({AW'(i), rx_fr[i]});
         bad = bad | rx_bad(rx_fr[i]);
      end
      done_q.push_back(bad);
      pulse_start(2'b01, AW'(0), AW'(rx_fr.size() - 1));
      check("err_cleared_on_start", 32'(err), 32'd0);
      tick(5);
      foreach (rx_fr[i]) send_rx_frame(rx_fr[i]);
      wait_idle(200);
      check("rx_err", 32'(err), 32'(bad));
   endtask

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic [FW-1:0] f;
      int d;
      tick(4);
      rst = 1'b0;
      tick(1);
      check("rst_pwdata", 32'(pwdata), 32'd1);
      check("rst_csb0", 32'(csb0), 32'd1);
      check("rst_web0", 32'(web0), 32'd1);
      check("rst_addr0", 32'(addr0), 32'd0);
      check("rst_o_data", 32'(o_data), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_err", 32'(err), 32'd0);

      // directed two-frame transmit
      mem[0] = 12'hF55;
      mem[1] = 12'h001;
      run_tx(2'b00, 2, 1'b0);

      for (int t = 0; t < 3; t++)
         run_tx(($urandom_range(1) != 0) ? 2'b11 : 2'b00, int'($urandom_range(1, 4)), 1'b1);

      // directed single receive with jitter
      rx_fr.delete();
      rx_fr.push_back(12'hC2A);
      run_rx();

      for (int t = 0; t < 3; t++) begin
         rx_fr.delete();
         for (int i = 0; i < int'($urandom_range(1, 3)); i++) rx_fr.push_back(rand_rx_frame());
         run_rx();
      end

      // stop bit 11 low: stored anyway, err sticky until next start
      rx_fr.delete();
      rx_fr.push_back(12'h42A);
      run_rx();
      tick(30);
      check("err_sticky", 32'(err), 32'd1);
      rx_fr.delete();
      rx_fr.push_back(12'hC2A);
      run_rx();

      // TX then RX with a frame on the line
      mem[0] = FW'($urandom);
      tx_q.push_back({AW'(0), mem[0]});
      f = rand_rx_frame();
      wr_q.push_back({AW'(0), f});
      done_q.push_back(rx_bad(f));
      pulse_start(2'b10, AW'(0), AW'(0));
      wait_txq(0, 50);
      tick(FW * BD + 10);
      send_rx_frame(f);
      wait_idle(200);

      // TX then RX with a silent line: timeout
      mem[0] = FW'($urandom);
      tx_q.push_back({AW'(0), mem[0]});
      done_q.push_back(1'b1);
      pulse_start(2'b10, AW'(0), AW'(1));
      wait_idle(FW * BD + TO + 200);
      check("timeout_err", 32'(err), 32'd1);
      d = done_cyc - tx_end_cyc;
      n_cmp++;
      if (d < TO || d > TO + 2) begin
         n_bad++;
         $display("FAIL timeout_delay: actual=%0d required=%0d..%0d", d, TO, TO + 2);
      end

      // reset in the middle of frame 3, with an ignored start while busy
      for (int i = 0; i < 6; i++) begin
         mem[i] = FW'($urandom);
         tx_q.push_back({AW'(i), mem[i]});
      end
      pulse_start(2'b00, AW'(5), AW'(0));
      wait_txq(5, 50);
      tick(30);
      pulse_start(2'b01, AW'(0), AW'(0));
      check("start_ignored_busy", 32'(busy), 32'd1);
      wait_txq(2, 4 * FW * BD);
      tick(40);
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      tx_q.delete();
      check("abort_pwdata", 32'(pwdata), 32'd1);
      check("abort_csb0", 32'(csb0), 32'd1);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      tick(3 * FW * BD);
      check("abort_idle_busy", 32'(busy), 32'd0);

      check("tx_q_drained", 32'(tx_q.size()), 32'd0);
      check("wr_q_drained", 32'(wr_q.size()), 32'd0);
      check("done_q_drained", 32'(done_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
